led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer_pkg.sv | 33 +++
 rtl/led_pattern_table.sv | 48 ++++
 rtl/led_pattern_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer_pkg
// Shared definitions for the LED pattern sequencer:
//   - state_e          : sequencer FSM states
//   - ADDR_*           : config slave word addresses
//   - CTRL_* / STATUS_*: bit positions inside the CTRL and STATUS registers
//   - PIO_DATA_ADDR    : PIO register the pattern is written to
// -----------------------------------------------------------------------------
package led_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_STATUS     = 4'd1;
    localparam logic [3:0] ADDR_INTERVAL   = 4'd2;
    localparam logic [3:0] ADDR_LENGTH     = 4'd3;
    localparam logic [3:0] ADDR_TABLE_BASE = 4'd8;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_ONE_SHOT_BIT = 1;

    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_INDEX_LSB  = 1;
    localparam int STATUS_DONE_BIT   = 8;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/led_pattern_table.sv
// -----------------------------------------------------------------------------
// led_pattern_table
// DEPTH x LED_W register file holding the LED patterns.
//   clk, reset        : clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata  : single write port, takes effect on the clk edge
//   raddr_a / rdata_a : async read port used by the sequencer (current index)
//   raddr_b / rdata_b : async read port used by the config slave readback
// A write and a read of the same entry in one cycle returns the old value,
// since reads come straight from the stored flops.
// -----------------------------------------------------------------------------
module led_pattern_table #(
    parameter  int LED_W = 8,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [LED_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [LED_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [LED_W-1:0] rdata_b
);

    logic [LED_W-1:0] mem_q [DEPTH];
    logic [LED_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
// Steps through a programmable table of LED patterns and writes each one to a
// PIO peripheral, holding each pattern for a programmable interval.
//   clk, reset           : single clock, asynchronous active-high reset
//   s_address[3:0]       : config slave word address
//   s_chipselect         : config slave select
//   s_write_n            : config slave active-low write
//   s_writedata[31:0]    : config slave write data
//   s_readdata[31:0]     : config slave read data (combinational, no wait states)
//   m_address[1:0]       : PIO register address (always the data register)
//   m_chipselect         : PIO select, high only in the WRITE state
//   m_write_n            : PIO active-low write, low only in the WRITE state
//   m_writedata[31:0]    : pattern being written, zero outside WRITE
//
// Bus semantics: a slave write is s_chipselect=1 with s_write_n=0 and commits
// on that clk edge; there is no backpressure. Reads need no select and are
// valid in the same cycle as s_address. A master write is a single-cycle
// strobe; the PIO is assumed to always accept it.
// -----------------------------------------------------------------------------
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic             one_shot_q, one_shot_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wr_en;
    logic [3:0]       tbl_off;
    logic             tbl_hit;
    logic [LEN_W-1:0] eff_len;
    logic             last_entry;
    logic             busy;
    logic             done;
    logic [LED_W-1:0] tbl_rdata_a;
    logic [LED_W-1:0] tbl_rdata_b;
    logic             unused_bits;

    assign wr_en   = s_chipselect && !s_write_n;
    assign tbl_off = s_address - ADDR_TABLE_BASE;
    assign tbl_hit = (s_address >= ADDR_TABLE_BASE) && (32'(tbl_off) < DEPTH);

    // Only the low bits of the write data and table offset are meaningful.
    assign unused_bits = ^{s_writedata, tbl_off};

    led_pattern_table #(
        .LED_W (LED_W),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en && tbl_hit),
        .waddr   (tbl_off[IDX_W-1:0]),
        .wdata   (s_writedata[LED_W-1:0]),
        .raddr_a (index_q),
        .rdata_a (tbl_rdata_a),
        .raddr_b (tbl_off[IDX_W-1:0]),
        .rdata_b (tbl_rdata_b)
    );

    // Config register updates.
    always_comb begin
        enable_d   = enable_q;
        one_shot_d = one_shot_q;
        interval_d = interval_q;
        length_d   = length_q;
        if (wr_en) begin
            case (s_address)
                ADDR_CTRL: begin
                    enable_d   = s_writedata[CTRL_ENABLE_BIT];
                    one_shot_d = s_writedata[CTRL_ONE_SHOT_BIT];
                end
                ADDR_INTERVAL: interval_d = s_writedata[CNT_W-1:0];
                ADDR_LENGTH:   length_d   = s_writedata[LEN_W-1:0];
                default: begin
                end
            endcase
        end
    end

    // LENGTH clamped into 1..DEPTH.
    always_comb begin
        if (length_q == '0) begin
            eff_len = LEN_W'(1);
        end else if (32'(length_q) > DEPTH) begin
            eff_len = LEN_W'(DEPTH);
        end else begin
            eff_len = length_q;
        end
    end

    assign last_entry = ({1'b0, index_q} >= (eff_len - LEN_W'(1)));

    // Sequencer next-state. The incoming CTRL value (enable_d) is used so a
    // clearing write lands in IDLE on the same edge it commits; the WRITE
    // cycle in progress at that moment has already driven its strobe.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        if (!enable_d) begin
            state_d = ST_IDLE;
            index_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WRITE;
                    index_d = '0;
                end
                ST_WRITE: begin
                    state_d = ST_WAIT;
                    count_d = interval_q;
                end
                ST_WAIT: begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else if (last_entry) begin
                        index_d = '0;
                        state_d = one_shot_q ? ST_DONE : ST_WRITE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_WRITE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            one_shot_q <= 1'b0;
            interval_q <= '0;
            length_q   <= '0;
            index_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            one_shot_q <= one_shot_d;
            interval_q <= interval_d;
            length_q   <= length_d;
            index_q    <= index_d;
            count_q    <= count_d;
        end
    end

    assign busy = (state_q == ST_WRITE) || (state_q == ST_WAIT);
    assign done = (state_q == ST_DONE);

    // PIO master: one strobe per WRITE cycle.
    assign m_address    = PIO_DATA_ADDR;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = (state_q != ST_WRITE);
    assign m_writedata  = (state_q == ST_WRITE) ? 32'(tbl_rdata_a) : 32'h0;

    // Config readback.
    always_comb begin
        s_readdata = 32'h0;
        case (s_address)
            ADDR_CTRL: begin
                s_readdata[CTRL_ENABLE_BIT]   = enable_q;
                s_readdata[CTRL_ONE_SHOT_BIT] = one_shot_q;
            end
            ADDR_STATUS: begin
                s_readdata[STATUS_BUSY_BIT]                = busy;
                s_readdata[STATUS_INDEX_LSB +: IDX_W]      = index_q;
                s_readdata[STATUS_DONE_BIT]                = done;
            end
            ADDR_INTERVAL: s_readdata = 32'(interval_q);
            ADDR_LENGTH:   s_readdata = 32'(length_q);
            default: begin
                if (tbl_hit) begin
                    s_readdata = 32'(tbl_rdata_b);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
// Self-checking bench for led_pattern_sequencer (default parameters).
// Strobes seen on the PIO master are logged with the cycle they occur in and
// compared with a list generated from the sequencing rules: strobe k of a run
// started at cycle t0 occurs at t0 + k*(INTERVAL+2) and carries
// table[k mod effective_length].
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s_address = 4'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = 32'h0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          obs_t_q[$];
    logic [31:0] obs_d_q[$];
    int          exp_t_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  tbl_m [8];
    logic [31:0] rd;

    led_pattern_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- strobe monitor ----------------
    always @(negedge clk) begin
        if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
            obs_t_q.push_back(cyc);
            obs_d_q.push_back(m_writedata);
            n_checks++;
            if (m_address !== 2'd0) begin
                n_fail++;
                $display("FAIL strobe_address: got %0d expected 0 at cycle %0d", m_address, cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_address    = addr;
        s_writedata  = data;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        s_address = addr;
        #1;
        data = s_readdata;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            bus_write(4'(8 + i), {24'h0, tbl_m[i]});
        end
    endtask

    task automatic start_run(input int ival, input int len_reg, input bit os, output int t0);
        bus_write(4'd2, 32'(ival));
        bus_write(4'd3, 32'(len_reg));
        obs_t_q.delete();
        obs_d_q.delete();
        bus_write(4'd0, {30'h0, os, 1'b1});
        t0 = cyc;
    endtask

    // Clearing write commits on the edge that makes cyc == t_at.
    task automatic stop_run(input int t_at, input int idle, output int t_stop);
        wait_cyc(t_at - 1);
        bus_write(4'd0, 32'h0);
        t_stop = cyc;
        repeat (idle) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_len(input int len_reg);
        if (len_reg == 0) return 1;
        if (len_reg > 8) return 8;
        return len_reg;
    endfunction

    task automatic build_expected(input int t0, input int t_end, input int ival,
                                  input int len_reg, input bit os);
        int eff, period, k;
        eff    = eff_len(len_reg);
        period = ival + 2;
        exp_t_q.delete();
        exp_q.delete();
        k = 0;
        while ((t0 + k * period) < t_end && !(os && k >= eff)) begin
            exp_t_q.push_back(t0 + k * period);
            exp_q.push_back({24'h0, tbl_m[k % eff]});
            k++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_master: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0",
                     m_chipselect, m_write_n, m_address, m_writedata);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", a, rd);
            end
        end
        for (int i = 0; i < 8; i++) tbl_m[i] = 8'h00;
    endtask

    task automatic test_register_map();
        logic [31:0] exp;
        logic [3:0]  addrs [6];
        logic [31:0] wdat  [6];
        logic [31:0] rexp  [6];
        addrs = '{4'd2, 4'd3, 4'd0, 4'd4, 4'd1, 4'd9};
        wdat  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234};
        rexp  = '{32'h00FF_FFFF, 32'h0000_000F, 32'h0,        32'h0,        32'h0,        32'h0000_0034};
        for (int i = 0; i < 6; i++) begin
            bus_write(addrs[i], wdat[i]);
            bus_read(addrs[i], rd);
            exp = rexp[i];
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL regmap_addr%0d: got %h expected %h", addrs[i], rd, exp);
            end
        end
        tbl_m[1] = 8'h34;
        n_checks++;
        if (obs_t_q.size() != 0) begin
            n_fail++;
            $display("FAIL regmap_no_strobe: got %0d strobes expected 0", obs_t_q.size());
        end
    endtask

    task automatic test_cycle();
        int t0, t_stop;
        tbl_m[0] = 8'h01; tbl_m[1] = 8'h02; tbl_m[2] = 8'h04; tbl_m[3] = 8'h08;
        load_table(4);
        start_run(3, 4, 1'b0, t0);
        wait_cyc(t0 + 7);
        bus_read(4'd1, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++;
            $display("FAIL cycle_status: got %h expected 00000003", rd);
        end
        stop_run(t0 + 21, 10, t_stop);
        build_expected(t0, t_stop, 3, 4, 1'b0);
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size() || exp_q.size() != 5) begin
            n_fail++;
            $display("FAIL cycle_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL cycle_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
    endtask

    task automatic test_one_shot();
        int t0, t_stop;
        tbl_m[0] = 8'hAA; tbl_m[1] = 8'h55;
        load_table(2);
        start_run(0, 2, 1'b1, t0);
        wait_cyc(t0 + 10);
        bus_read(4'd1, rd);
        n_checks++;
        if (rd !== 32'h100) begin
            n_fail++;
            $display("FAIL oneshot_done_status: got %h expected 00000100", rd);
        end
        stop_run(t0 + 12, 4, t_stop);
        bus_read(4'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oneshot_cleared_status: got %h expected 00000000", rd);
        end
        build_expected(t0, t_stop, 0, 2, 1'b1);
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size() || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL oneshot_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL oneshot_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
    endtask

    task automatic test_length_zero();
        int t0, t_stop, ival, p;
        ival = $urandom_range(0, 4);
        p = ival + 2;
        tbl_m[0] = 8'h81;
        load_table(1);
        start_run(ival, 0, 1'b0, t0);
        for (int j = 0; j < 5; j++) begin
            wait_cyc(t0 + j * p + 1);
            bus_read(4'd1, rd);
            n_checks++;
            if (rd !== 32'h1) begin
                n_fail++;
                $display("FAIL len0_status%0d: got %h expected 00000001", j, rd);
            end
        end
        stop_run(t0 + 6 * p + 1, 6, t_stop);
        build_expected(t0, t_stop, ival, 0, 1'b0);
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size()) begin
            n_fail++;
            $display("FAIL len0_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL len0_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
    endtask

    task automatic test_disable_mid();
        int t0, t_stop;
        tbl_m[0] = 8'h01; tbl_m[1] = 8'h02; tbl_m[2] = 8'h04; tbl_m[3] = 8'h08;
        load_table(4);
        start_run(5, 4, 1'b0, t0);
        wait_cyc(t0 + 16);
        bus_read(4'd1, rd);
        n_checks++;
        if (rd !== 32'h5) begin
            n_fail++;
            $display("FAIL disable_wait_status: got %h expected 00000005", rd);
        end
        stop_run(t0 + 17, 30, t_stop);
        bus_read(4'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL disable_status: got %h expected 00000000", rd);
        end
        build_expected(t0, t_stop, 5, 4, 1'b0);
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size() || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL disable_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL disable_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
        // Restart must begin again at table[0].
        start_run(5, 4, 1'b0, t0);
        stop_run(t0 + 10, 6, t_stop);
        build_expected(t0, t_stop, 5, 4, 1'b0);
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size()) begin
            n_fail++;
            $display("FAIL restart_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL restart_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
    endtask

    task automatic test_table_update();
        int t0, t_stop, t_w;
        tbl_m[0] = 8'h01; tbl_m[1] = 8'h02; tbl_m[2] = 8'h04; tbl_m[3] = 8'h08;
        load_table(4);
        start_run(3, 4, 1'b0, t0);
        t_w = t0 + 5;
        wait_cyc(t_w);
        bus_write(4'd9, 32'h0000_00FF);
        stop_run(t0 + 30, 6, t_stop);
        build_expected(t0, t_stop, 3, 4, 1'b0);
        foreach (exp_q[i]) if (exp_t_q[i] > t_w && (i % 4) == 1) exp_q[i] = 32'h0000_00FF;
        tbl_m[1] = 8'hFF;
        n_checks++;
        if (obs_t_q.size() != exp_t_q.size()) begin
            n_fail++;
            $display("FAIL tblupd_count: got %0d strobes expected %0d", obs_t_q.size(), exp_t_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d_q.size()) begin
            n_checks++;
            if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                n_fail++;
                $display("FAIL tblupd_strobe%0d: got %h@%0d expected %h@%0d",
                         i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, n_before;
        start_run(6, 4, 1'b0, t0);
        wait_cyc(t0 + 3);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({m_chipselect, m_write_n, m_writedata} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_master: got cs=%b wn=%b d=%h expected cs=0 wn=1 d=0",
                     m_chipselect, m_write_n, m_writedata);
        end
        for (int a = 0; a < 12; a++) begin
            bus_read(4'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_reg%0d: got %h expected 00000000", a, rd);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tbl_m[i] = 8'h00;
        n_before = obs_t_q.size();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (obs_t_q.size() != n_before || n_before != 1) begin
            n_fail++;
            $display("FAIL rstmid_strobes: got %0d strobes expected 1", obs_t_q.size());
        end
    endtask

    task automatic test_random();
        int t0, t_stop, ival, len_reg, eff, p, check_at, k;
        bit os;
        logic [31:0] exp;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) tbl_m[i] = 8'($urandom_range(0, 255));
            load_table(8);
            ival    = $urandom_range(0, 4);
            len_reg = $urandom_range(0, 15);
            os      = 1'($urandom_range(0, 1));
            eff     = eff_len(len_reg);
            p       = ival + 2;
            start_run(ival, len_reg, os, t0);
            check_at = t0 + (eff + 1) * p + $urandom_range(0, 5);
            wait_cyc(check_at);
            bus_read(4'd1, rd);
            k = (check_at - t0) / p;
            exp = os ? 32'h100 : (32'h1 | (32'(k % eff) << 1));
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL rand%0d_status: got %h expected %h", it, rd, exp);
            end
            stop_run(check_at + 1, 6, t_stop);
            build_expected(t0, t_stop, ival, len_reg, os);
            n_checks++;
            if (obs_t_q.size() != exp_t_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d strobes expected %0d",
                         it, obs_t_q.size(), exp_t_q.size());
            end
            foreach (exp_q[i]) if (i < obs_d_q.size()) begin
                n_checks++;
                if (obs_d_q[i] !== exp_q[i] || obs_t_q[i] != exp_t_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_strobe%0d: got %h@%0d expected %h@%0d",
                             it, i, obs_d_q[i], obs_t_q[i], exp_q[i], exp_t_q[i]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_register_map();
        test_cycle();
        test_one_shot();
        test_length_zero();
        test_disable_mid();
        test_table_update();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
